bus_rr_arbiter: RTL

Round-robin arbiter sharing one 8-bit valid/ready bus (bus_if master/slave signalling) among NUM_REQ sender-side requesters.
- Grants one requester at a time, locked for a burst (until last beat or MAX_BURST beats).
- Forwards beats through a single registered output stage toward the receiver side.
- Sits between multiple sender modules and one bus_if slave-facing receiver.

---
 rtl/bus_arb_pkg.sv | 22 ++
 rtl/rr_picker.sv | 38 +++
 rtl/bus_rr_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg
// Shared definitions for the round-robin bus arbiter slice.
//   arb_state_e    : arbiter state (IDLE between grants, BURST while locked)
//   DEFAULT_DATA_W : default beat width, matches the bus_if data width
//   safe_clog2()   : index width helper that never returns 0
// -----------------------------------------------------------------------------
package bus_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEFAULT_DATA_W = 8;

  // $clog2(1) is 0, which would give a zero-width index; clamp to 1 bit.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational find-first-set starting at a rotating pointer.
//   req     : request vector, one bit per requester
//   ptr     : search start position (wraps modulo NUM_REQ)
//   pick    : index of the first set request at or after ptr
//   any_req : high when at least one request bit is set
// -----------------------------------------------------------------------------
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = safe_clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   pick,
  output logic               any_req
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset back toward ptr so the closest hit
  // (smallest offset) is the one left standing.
  always_comb begin
    pick    = ptr;
    any_req = 1'b0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        pick    = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter
// Round-robin arbiter sharing one valid/ready bus among NUM_REQ senders.
// A grant is locked for a burst (until the last beat or MAX_BURST beats) and
// beats are forwarded through a single registered output stage.
//   clk, rst_n               : clock, asynchronous active-low reset
//   req_valid/data/last      : per-requester beat inputs (data packed by index)
//   req_ready                : per-requester beat accepted
//   out_valid/data/last      : registered output beat toward the receiver
//   out_ready                : downstream ready
//   grant_id                 : current or most recent grantee
//   busy                     : high while a grant is held
// -----------------------------------------------------------------------------
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = DEFAULT_DATA_W,
  parameter  int MAX_BURST = 8,
  localparam int IDX_W     = safe_clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy
);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_last_q, out_last_d;

  logic [IDX_W-1:0]   pick;
  logic               any_req;
  logic               g_valid;
  logic               g_last;
  logic [DATA_W-1:0]  g_data;
  logic               out_free;
  logic               accept;
  logic [NUM_REQ-1:0] req_ready_c;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .pick    (pick),
    .any_req (any_req)
  );

  // Signals of the currently granted requester.
  always_comb begin
    g_valid = req_valid[grant_q];
    g_last  = req_last[grant_q];
    g_data  = req_data[int'(grant_q) * DATA_W +: DATA_W];
  end

  // The output register can take a new beat if it is empty or draining now.
  assign out_free = !out_valid_q || out_ready;

  // Next-state logic. The output drain is evaluated first so that a beat
  // accepted in the same cycle overrides the clear.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    busy_d      = busy_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    req_ready_c = '0;
    accept      = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = BURST;
          grant_d    = pick;
          busy_d     = 1'b1;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        req_ready_c[grant_q] = out_free;
        accept = g_valid && out_free;
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = g_data;
          out_last_d  = g_last;
          beat_cnt_d  = beat_cnt_q + CNT_W'(1);
          // Release on the sender's last beat or when the burst cap is hit;
          // out_last is passed through untouched in the cap case.
          if (g_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      busy_q      <= 1'b0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      busy_q      <= busy_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign req_ready = req_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;

endmodule
